// File: rtl/hardcore_linux_pulse_pio.sv
// Avalon-MM output PIO: per-channel base level, one-shot pulse timers
// that invert the level, sticky done flags and a maskable level IRQ.
module hardcore_linux_pulse_pio #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_LEN   = 3'd1;
  localparam logic [2:0] A_START = 3'd2;
  localparam logic [2:0] A_DONE  = 3'd3;
  localparam logic [2:0] A_MASK  = 3'd4;
  localparam logic [2:0] A_SET   = 3'd5;
  localparam logic [2:0] A_CLR   = 3'd6;

  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_done;
  logic [WIDTH-1:0] r_mask;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_start;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_busy;
  logic [WIDTH-1:0] w_set;
  logic             w_len_zero;
  logic [31:0]      w_rd;
  logic             w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_wd       = writedata[WIDTH-1:0];
  assign w_start    = (w_wr && address == A_START) ? w_wd : '0;
  assign w_clr      = (w_wr && address == A_DONE) ? w_wd : '0;
  assign w_len_zero = (r_len == '0);
  assign w_unused   = &{1'b0, writedata};

  // A zero-length start completes on the same edge it is sampled.
  always_comb begin
    w_busy = '0;
    w_set  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_busy[i] = (r_cnt[i] != '0);
      if (w_start[i])
        w_set[i] = w_len_zero;
      else
        w_set[i] = (r_cnt[i] == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_start[i])
          r_cnt[i] <= r_len;
        else if (w_busy[i])
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_len  <= '0;
      r_mask <= '0;
      r_done <= '0;
    end else begin
      r_done <= (r_done & ~w_clr) | w_set;
      if (w_wr) begin
        case (address)
          A_DATA: r_data <= w_wd;
          A_LEN:  r_len  <= writedata[CNT_W-1:0];
          A_MASK: r_mask <= w_wd;
          A_SET:  r_data <= r_data | w_wd;
          A_CLR:  r_data <= r_data & ~w_wd;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      A_DATA:  w_rd[WIDTH-1:0] = r_data;
      A_LEN:   w_rd[CNT_W-1:0] = r_len;
      A_START: w_rd[WIDTH-1:0] = w_busy;
      A_DONE:  w_rd[WIDTH-1:0] = r_done;
      A_MASK:  w_rd[WIDTH-1:0] = r_mask;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_readdata <= '0;
    else
      r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign out_port = r_data ^ w_busy;
  assign irq      = |(r_done & r_mask);

endmodule

// File: tb/tb_hardcore_linux_pulse_pio.sv
// Self-checking bench for hardcore_linux_pulse_pio: register vector
// table plus hand-written pulse, retrigger, IRQ and reset sequences.
module tb_hardcore_linux_pulse_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  out_port;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    logic [2:0]  a;
    logic [31:0] exp;
  } sb_t;

  vec_t tbl [14];
  sb_t  sbq [$];

  hardcore_linux_pulse_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    sb_t e;
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sbq.push_back('{a: a, exp: exp});
    step();
    idle();
    if (sbq.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard empty on read");
    end else begin
      e = sbq.pop_front();
      chk($sformatf("read addr %0d", e.a), readdata, e.exp);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 32'h5,        4'b0101, 32'h0};
    tbl[1]  = '{1'b1, 3'd5, 32'h2,        4'b0111, 32'h0};
    tbl[2]  = '{1'b1, 3'd6, 32'h1,        4'b0110, 32'h0};
    tbl[3]  = '{1'b0, 3'd0, 32'h0,        4'b0110, 32'h6};
    tbl[4]  = '{1'b0, 3'd5, 32'h0,        4'b0110, 32'h0};
    tbl[5]  = '{1'b0, 3'd6, 32'h0,        4'b0110, 32'h0};
    tbl[6]  = '{1'b1, 3'd7, 32'hFFFFFFFF, 4'b0110, 32'h0};
    tbl[7]  = '{1'b0, 3'd7, 32'h0,        4'b0110, 32'h0};
    tbl[8]  = '{1'b1, 3'd1, 32'hFFFFFFFF, 4'b0110, 32'h0};
    tbl[9]  = '{1'b0, 3'd1, 32'h0,        4'b0110, 32'hFFFFFF};
    tbl[10] = '{1'b1, 3'd4, 32'hA5,       4'b0110, 32'h0};
    tbl[11] = '{1'b0, 3'd4, 32'h0,        4'b0110, 32'h5};
    tbl[12] = '{1'b1, 3'd0, 32'hFFFFFFF9, 4'b1001, 32'h0};
    tbl[13] = '{1'b0, 3'd0, 32'h0,        4'b1001, 32'h9};

    #23 reset = 1'b0;
    chk("reset readdata", readdata, 32'h0);
    chk("reset out_port", {28'h0, out_port}, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);
    step();

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].is_wr)
        wr(tbl[i].a, tbl[i].d);
      else
        rd(tbl[i].a, tbl[i].exp_rd);
      chk($sformatf("vec %0d out_port", i), {28'h0, out_port},
          {28'h0, tbl[i].exp_out});
    end
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h0);

    // 3-cycle pulse on channel 0, mask off
    wr(3'd1, 32'd3);
    wr(3'd2, 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("pulse3 out k=%0d", k), {31'h0, out_port[0]},
          {31'h0, k < 3});
      chk($sformatf("pulse3 irq k=%0d", k), {31'h0, irq}, 32'h0);
      step();
    end
    rd(3'd3, 32'h1);
    rd(3'd2, 32'h0);

    // IRQ rise, clear, and clear colliding with pulse end
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h1);
    chk("irq after clear", {31'h0, irq}, 32'h0);
    wr(3'd2, 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("irq pulse k=%0d", k), {31'h0, irq}, {31'h0, k == 3});
      if (k < 3) step();
    end
    wr(3'd3, 32'h1);
    chk("irq cleared", {31'h0, irq}, 32'h0);
    wr(3'd2, 32'h1);
    step();
    step();
    wr(3'd3, 32'h1);
    chk("irq set beats clear", {31'h0, irq}, 32'h1);
    rd(3'd3, 32'h1);
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h2);

    // retrigger channel 1 at cycle 4
    wr(3'd1, 32'd10);
    wr(3'd2, 32'h2);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("retrig out k=%0d", k), {31'h0, out_port[1]},
          {31'h0, k < 14});
      chk($sformatf("retrig irq k=%0d", k), {31'h0, irq},
          {31'h0, k >= 14});
      if (k == 3) wr(3'd2, 32'h2);
      else step();
    end
    rd(3'd3, 32'h2);
    wr(3'd3, 32'h2);
    wr(3'd4, 32'h0);

    // base level changes and LEN writes while a pulse runs
    wr(3'd1, 32'd4);
    wr(3'd2, 32'h4);
    chk("lvl k0", {28'h0, out_port}, 32'h4);
    wr(3'd5, 32'h4);
    chk("lvl k1", {28'h0, out_port}, 32'h0);
    wr(3'd1, 32'd1);
    chk("lvl k2", {28'h0, out_port}, 32'h0);
    step();
    chk("lvl k3", {28'h0, out_port}, 32'h0);
    step();
    chk("lvl k4", {28'h0, out_port}, 32'h4);
    wr(3'd3, 32'h4);
    wr(3'd0, 32'h0);

    // zero-length pulse on all channels
    wr(3'd1, 32'd0);
    wr(3'd2, 32'hF);
    chk("zero len out", {28'h0, out_port}, 32'h0);
    rd(3'd3, 32'hF);
    rd(3'd2, 32'h0);
    chk("zero len irq", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'hF);

    // reset in the middle of a pulse (cnt=5)
    wr(3'd0, 32'hF);
    wr(3'd4, 32'hF);
    wr(3'd2, 32'h2);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'h1);
    step();
    step();
    step();
    chk("pre-reset out", {28'h0, out_port}, 32'hE);
    chk("pre-reset irq", {31'h0, irq}, 32'h1);
    reset = 1'b1;
    #1;
    chk("async reset out", {28'h0, out_port}, 32'h0);
    chk("async reset irq", {31'h0, irq}, 32'h0);
    chk("async reset rd", readdata, 32'h0);
    step();
    #3 reset = 1'b0;
    step();
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0);
    for (int k = 0; k < 8; k++) step();
    rd(3'd3, 32'h0);
    chk("post-reset out", {28'h0, out_port}, 32'h0);
    chk("post-reset irq", {31'h0, irq}, 32'h0);

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard leftover: %0d entries, expected 0",
               sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
